// File: rtl/enemy_draw_pkg.sv
// Shared enemy-formation constants, VGA timing bundle and index encoding.
// The missile and collision blocks use the same row*COLS+col numbering.
package enemy_draw_pkg;

  localparam int DEF_COLS = 5;
  localparam int DEF_ROWS = 2;
  localparam int DEF_W    = 32;
  localparam int DEF_H    = 32;
  localparam int DEF_SPX  = 64;
  localparam int DEF_SPY  = 48;
  localparam logic [11:0] DEF_RGB = 12'hF00;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } vga_t;

  localparam int VGA_W = $bits(vga_t);

  function automatic int enemy_idx(int r, int c, int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/signal_delay.sv
// Fixed-depth register chain, cleared by synchronous reset.
// Carries the VGA timing bundle alongside the pixel pipeline.
module signal_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/enemy_draw.sv
// Overlays a ROWS x COLS grid of enemy rectangles on the VGA stream.
// Tracks alive enemies, kills by index, reloads the grid on level change.
module enemy_draw
  import enemy_draw_pkg::*;
#(
  parameter int ENEMY_COLS = DEF_COLS,
  parameter int ENEMY_ROWS = DEF_ROWS,
  parameter int ENEMY_W    = DEF_W,
  parameter int ENEMY_H    = DEF_H,
  parameter int SPACING_X  = DEF_SPX,
  parameter int SPACING_Y  = DEF_SPY,
  parameter logic [11:0] ENEMY_RGB = DEF_RGB,
  localparam int N = ENEMY_ROWS * ENEMY_COLS
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic [10:0]  hcount_in,
  input  logic [10:0]  vcount_in,
  input  logic         hsync_in,
  input  logic         vsync_in,
  input  logic         hblnk_in,
  input  logic         vblnk_in,
  input  logic [11:0]  rgb_in,
  input  logic [10:0]  x_base,
  input  logic [10:0]  y_base,
  input  logic [3:0]   level,
  input  logic         kill_valid,
  input  logic [3:0]   kill_idx,
  output logic [10:0]  hcount_out,
  output logic [10:0]  vcount_out,
  output logic         hsync_out,
  output logic         vsync_out,
  output logic         hblnk_out,
  output logic         vblnk_out,
  output logic [11:0]  rgb_out,
  output logic [N-1:0] alive_mask,
  output logic         all_dead
);

  logic [10:0]  x_lat_q, y_lat_q;
  logic         vblnk_prev_q;
  logic [3:0]   level_lat_q;
  logic [N-1:0] alive_q, alive_d;
  logic         all_dead_q;
  logic [N-1:0] hit_d, hit_q;
  logic [11:0]  rgb1_q, rgb_q;
  logic         blank1_q;
  vga_t         vga_in, vga_out;

  // Position only moves on a vblank rise so a frame never tears.
  always_ff @(posedge pclk) begin
    if (rst) begin
      x_lat_q      <= '0;
      y_lat_q      <= '0;
      vblnk_prev_q <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      if (vblnk_in && !vblnk_prev_q) begin
        x_lat_q <= x_base;
        y_lat_q <= y_base;
      end
    end
  end

  always_comb begin
    alive_d = alive_q;
    if (level != level_lat_q) begin
      alive_d = '1;
    end else if (kill_valid) begin
      for (int i = 0; i < N; i++)
        if (kill_idx == 4'(i))
          alive_d[i] = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      alive_q     <= '1;
      all_dead_q  <= 1'b0;
      level_lat_q <= level;
    end else begin
      alive_q     <= alive_d;
      all_dead_q  <= (alive_d == '0);
      level_lat_q <= level;
    end
  end

  // Bounds in 12 bits: cells past 2047 vanish instead of wrapping.
  for (genvar r = 0; r < ENEMY_ROWS; r++) begin : g_row
    for (genvar c = 0; c < ENEMY_COLS; c++) begin : g_col
      localparam int IDX = enemy_idx(r, c, ENEMY_COLS);
      localparam logic [11:0] OX = 12'(c * SPACING_X);
      localparam logic [11:0] OY = 12'(r * SPACING_Y);
      logic [11:0] x0, y0, hc, vc;
      assign x0 = {1'b0, x_lat_q} + OX;
      assign y0 = {1'b0, y_lat_q} + OY;
      assign hc = {1'b0, hcount_in};
      assign vc = {1'b0, vcount_in};
      assign hit_d[IDX] = alive_q[IDX] &
        (hc >= x0) & (hc < x0 + 12'(ENEMY_W)) &
        (vc >= y0) & (vc < y0 + 12'(ENEMY_H));
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hit_q    <= '0;
      rgb1_q   <= '0;
      blank1_q <= 1'b0;
      rgb_q    <= '0;
    end else begin
      hit_q    <= hit_d;
      rgb1_q   <= rgb_in;
      blank1_q <= hblnk_in | vblnk_in;
      if (blank1_q)
        rgb_q <= 12'h000;
      else if (|hit_q)
        rgb_q <= ENEMY_RGB;
      else
        rgb_q <= rgb1_q;
    end
  end

  assign vga_in = '{
    hcount: hcount_in, vcount: vcount_in,
    hsync: hsync_in, vsync: vsync_in,
    hblnk: hblnk_in, vblnk: vblnk_in
  };

  signal_delay #(
    .WIDTH(VGA_W),
    .DEPTH(2)
  ) u_tdly (
    .pclk(pclk),
    .rst (rst),
    .d_i (vga_in),
    .q_o (vga_out)
  );

  assign hcount_out = vga_out.hcount;
  assign vcount_out = vga_out.vcount;
  assign hsync_out  = vga_out.hsync;
  assign vsync_out  = vga_out.vsync;
  assign hblnk_out  = vga_out.hblnk;
  assign vblnk_out  = vga_out.vblnk;
  assign rgb_out    = rgb_q;
  assign alive_mask = alive_q;
  assign all_dead   = all_dead_q;

endmodule

// File: tb/tb_enemy_draw.sv
// Scoreboard bench for enemy_draw: stimulus queues expectations,
// a negedge monitor pops and compares them when they come due.
module tb_enemy_draw;

  logic        pclk;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] x_base, y_base;
  logic [3:0]  level;
  logic        kill_valid;
  logic [3:0]  kill_idx;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [9:0]  alive_mask;
  logic        all_dead;

  enemy_draw dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .x_base(x_base), .y_base(y_base),
    .level(level), .kill_valid(kill_valid), .kill_idx(kill_idx),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .alive_mask(alive_mask), .all_dead(all_dead)
  );

  typedef struct {
    int          due;
    bit          kind;
    logic [11:0] rgb;
    logic [25:0] tim;
    logic [9:0]  mask;
    logic        dead;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [9:0] exp_mask;
  localparam logic [11:0] BG = 12'h0AB;

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      me = q.pop_front();
      checks++;
      if (me.due < cyc) begin
        failures++;
        $display("FAIL %s: missed due cycle %0d (now %0d)", me.name, me.due, cyc);
      end else if (me.kind == 1'b0) begin
        if (rgb_out !== me.rgb ||
            {hcount_out, vcount_out, hsync_out, vsync_out,
             hblnk_out, vblnk_out} !== me.tim) begin
          failures++;
          $display("FAIL %s: rgb=%h tim=%h, expected rgb=%h tim=%h",
                   me.name, rgb_out,
                   {hcount_out, vcount_out, hsync_out, vsync_out,
                    hblnk_out, vblnk_out}, me.rgb, me.tim);
        end
      end else begin
        if (alive_mask !== me.mask || all_dead !== me.dead) begin
          failures++;
          $display("FAIL %s: mask=%h dead=%b, expected mask=%h dead=%b",
                   me.name, alive_mask, all_dead, me.mask, me.dead);
        end
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic push(exp_t e);
    int i;
    i = q.size();
    while (i > 0 && q[i-1].due > e.due) i--;
    q.insert(i, e);
  endtask

  task automatic pix(string nm, int h, int v, logic hb, logic [11:0] er);
    exp_t e;
    logic [10:0] h11, v11;
    h11 = h[10:0];
    v11 = v[10:0];
    hcount_in = h11;
    vcount_in = v11;
    hsync_in  = h11[0];
    vsync_in  = v11[0];
    hblnk_in  = hb;
    vblnk_in  = 1'b0;
    rgb_in    = BG;
    e.due  = cyc + 2;
    e.kind = 1'b0;
    e.rgb  = er;
    e.tim  = {h11, v11, h11[0], v11[0], hb, 1'b0};
    e.mask = '0;
    e.dead = 1'b0;
    e.name = nm;
    push(e);
    step();
  endtask

  task automatic mpush(string nm, int dly);
    exp_t e;
    e.due  = cyc + dly;
    e.kind = 1'b1;
    e.rgb  = '0;
    e.tim  = '0;
    e.mask = exp_mask;
    e.dead = (exp_mask == 10'h000);
    e.name = nm;
    push(e);
  endtask

  task automatic kill(string nm, int idx);
    kill_valid = 1'b1;
    kill_idx   = 4'(idx);
    if (idx < 10) exp_mask[idx] = 1'b0;
    mpush(nm, 1);
    step();
    kill_valid = 1'b0;
  endtask

  task automatic vblank_pulse();
    hblnk_in = 1'b0;
    vblnk_in = 1'b1;
    step();
    vblnk_in = 1'b0;
    step();
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    hcount_in = 11'd5; vcount_in = 11'd7;
    hsync_in = 1'b1; vsync_in = 1'b1;
    hblnk_in = 1'b1; vblnk_in = 1'b0;
    rgb_in = 12'hFFF;
    x_base = 11'd100; y_base = 11'd100;
    level = 4'd1;
    kill_valid = 1'b0; kill_idx = 4'd0;
    exp_mask = 10'h3FF;
    step(3);
    e.due = cyc; e.kind = 1'b0; e.rgb = '0; e.tim = '0;
    e.mask = '0; e.dead = 1'b0; e.name = "reset_pix";
    push(e);
    mpush("reset_mask", 0);
    step();
    rst = 1'b0;
    hblnk_in = 1'b0;

    vblank_pulse();
    pix("t1_hit",       100, 100, 1'b0, 12'hF00);
    pix("t1_right_out", 132, 100, 1'b0, BG);
    pix("t1_left_out",   99, 100, 1'b0, BG);
    pix("t1_corner",    131, 131, 1'b0, 12'hF00);
    pix("t1_below_out", 100, 132, 1'b0, BG);

    pix("t2_r1c1",      164, 148, 1'b0, 12'hF00);
    pix("t2_gap",       150, 120, 1'b0, BG);
    pix("t2_r1c4",      356, 148, 1'b0, 12'hF00);
    pix("t2_r1c4_last", 387, 179, 1'b0, 12'hF00);
    pix("t2_past_grid", 388, 179, 1'b0, BG);

    x_base = 11'd600;
    pix("t3_old_kept",  100, 100, 1'b0, 12'hF00);
    pix("t3_new_early", 600, 100, 1'b0, BG);
    vblank_pulse();
    pix("t3_new_drawn", 600, 100, 1'b0, 12'hF00);
    pix("t3_old_gone",  100, 100, 1'b0, BG);

    x_base = 11'd2030;
    vblank_pulse();
    pix("edge_hit",    2040, 100, 1'b0, 12'hF00);
    pix("edge_nowrap",    5, 100, 1'b0, BG);
    x_base = 11'd100;
    vblank_pulse();

    kill("t4_kill6", 6);
    pix("t4_dead_cell", 164, 148, 1'b0, BG);
    pix("t4_live_cell", 100, 100, 1'b0, 12'hF00);
    kill("t4_kill12_ign", 12);

    for (int i = 0; i < 10; i++)
      kill($sformatf("t5_kill%0d", i), i);
    pix("t5_all_dead_pix", 100, 100, 1'b0, BG);
    level = 4'd2;
    exp_mask = 10'h3FF;
    mpush("t5_reload", 1);
    step();
    pix("t5_reload_pix", 164, 148, 1'b0, 12'hF00);

    kill_valid = 1'b1;
    kill_idx = 4'd3;
    level = 4'd3;
    mpush("t6_kill_vs_reload", 1);
    step();
    kill_valid = 1'b0;
    pix("t6_hblank", 100, 100, 1'b1, 12'h000);
    pix("t6_after",  101, 101, 1'b0, 12'hF00);

    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations never came due", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
